// File: rtl/star_pkg.sv
// Shared flit-type codes, port count and requester FSM encoding for the star router.
package star_pkg;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam int NPORT = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_XFER    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  // A flit that opens a packet (carries a destination).
  function automatic logic ft_is_head(input logic [1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_SINGLE);
  endfunction

  // A flit that closes a packet.
  function automatic logic ft_is_tail(input logic [1:0] ft);
    return (ft == FT_TAIL) || (ft == FT_SINGLE);
  endfunction

  // A flit that may only appear inside a packet.
  function automatic logic ft_is_inner(input logic [1:0] ft);
    return (ft == FT_BODY) || (ft == FT_TAIL);
  endfunction

endpackage

// File: rtl/star_flit_fifo.sv
// Small registered flit FIFO; pointers carry one extra wrap bit for full/empty.
module star_flit_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [FLIT_W-1:0] i_din,
  output logic              o_full,
  output logic              o_empty,
  output logic [FLIT_W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer update; reset empties the buffer without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Flit storage write.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/star_port_requester.sv
// Router input port: buffers flits, requests the destination output arbiter,
// streams the packet while granted and releases only after the grant drops.
module star_port_requester #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int NPORT  = star_pkg::NPORT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NPORT-1:0]  req,
  input  logic [NPORT-1:0]  gnt,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              drop_err
);

  import star_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_dest;
  logic [NPORT-1:0]  r_req;

  logic              w_full;
  logic              w_empty;
  logic [FLIT_W-1:0] w_head;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_type;
  logic [3:0]        w_hdest;
  logic              w_dest_legal;
  logic              w_head_start;
  logic              w_gnt_sel;
  logic [3:0]        w_req_dest;
  logic              w_out_valid;
  logic              w_drop_err;

  function automatic logic [NPORT-1:0] onehot(input logic [3:0] d);
    logic [NPORT-1:0] v;
    for (int k = 0; k < NPORT; k++) v[k] = (int'(d) == k);
    return v;
  endfunction

  // Input is held off while full and while reset is asserted.
  assign in_ready     = !w_full && !rst;
  assign w_push       = in_valid && in_ready;
  assign w_type       = w_head[FLIT_W-1 -: 2];
  assign w_hdest      = w_head[3:0];
  assign w_dest_legal = (int'(w_hdest) < NPORT);
  assign w_head_start = !w_empty && ft_is_head(w_type);
  assign w_gnt_sel    = |(gnt & onehot(r_dest));
  assign w_req_dest   = (r_state == ST_IDLE) ? w_hdest : r_dest;

  star_flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (in_flit),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_head_start) w_state_nxt = w_dest_legal ? ST_REQ : ST_DROP;
      ST_REQ:     if (w_gnt_sel) w_state_nxt = ST_XFER;
      ST_XFER:    if (w_pop && ft_is_tail(w_type)) w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (!w_gnt_sel) w_state_nxt = ST_IDLE;
      ST_DROP:    if (w_pop && ft_is_tail(w_type)) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: pop, crossbar valid and discard pulse.
  always_comb begin
    w_pop       = 1'b0;
    w_out_valid = 1'b0;
    w_drop_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && ft_is_inner(w_type)) begin
          w_pop      = 1'b1;
          w_drop_err = 1'b1;
        end
      end
      ST_XFER: begin
        w_out_valid = !w_empty && w_gnt_sel;
        w_pop       = w_out_valid && out_ready;
      end
      ST_DROP: begin
        w_pop      = !w_empty;
        w_drop_err = !w_empty && ft_is_tail(w_type);
      end
      default: ;
    endcase
  end

  // Latched destination and registered one-hot request following the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dest <= '0;
      r_req  <= '0;
    end else begin
      if (r_state == ST_IDLE && w_head_start) r_dest <= w_hdest;
      if (w_state_nxt == ST_REQ || w_state_nxt == ST_XFER) r_req <= onehot(w_req_dest);
      else                                                   r_req <= '0;
    end
  end

  assign req       = r_req;
  assign out_valid = w_out_valid;
  assign out_flit  = w_out_valid ? w_head : '0;
  assign drop_err  = w_drop_err;

endmodule

// File: tb/tb_star_port_requester.sv
// Directed bench for the star router input-port requester.
module tb_star_port_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  req;
  logic [9:0]  gnt = '0;
  logic [15:0] out_flit;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        drop_err;

  int vecs = 0;
  int errs = 0;

  star_port_requester #(.FLIT_W(16), .DEPTH(4), .NPORT(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(); #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL rst_req got %h want %h", req, 10'h000); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vecs++; if (out_flit !== 16'h0000) begin errs++; $display("FAIL rst_out_flit got %h want 0000", out_flit); end
    vecs++; if (drop_err !== 1'b0) begin errs++; $display("FAIL rst_drop_err got %b want 0", drop_err); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready_held got %b want 0", in_ready); end
    cyc(); rst = 1'b0; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready_rel got %b want 1", in_ready); end
  endtask

  task automatic test_three_flit();
    logic [15:0] exp [3];
    exp = '{16'h4005, 16'h0123, 16'h8456};
    cyc(); in_valid = 1'b1; in_flit = 16'h4005; #1;
    cyc(); in_flit = 16'h0123; #1;
    cyc(); in_flit = 16'h8456; #1;
    vecs++; if (req !== 10'b0000100000) begin errs++; $display("FAIL p3_req_rise got %b want %b", req, 10'b0000100000); end
    cyc(); in_valid = 1'b0; #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL p3_nogrant_valid got %b want 0", out_valid); end
    cyc(); gnt = 10'b0000100000; #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL p3_gnt_cycle_valid got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL p3_beat%0d_valid got %b want 1", i, out_valid); end
      vecs++; if (out_flit !== exp[i]) begin errs++; $display("FAIL p3_beat%0d_flit got %h want %h", i, out_flit, exp[i]); end
      vecs++; if (req !== 10'b0000100000) begin errs++; $display("FAIL p3_beat%0d_req got %b want %b", i, req, 10'b0000100000); end
    end
    cyc(); #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL p3_release_req got %b want 0", req); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL p3_release_valid got %b want 0", out_valid); end
    cyc(); gnt = '0; #1;
    cyc(); #1;
  endtask

  task automatic test_single();
    cyc(); in_valid = 1'b1; in_flit = 16'hC009; #1;
    cyc(); in_valid = 1'b0; #1;
    cyc(); #1;
    vecs++; if (req !== 10'b1000000000) begin errs++; $display("FAIL single_req got %b want %b", req, 10'b1000000000); end
    cyc(); #1;
    cyc(); gnt = 10'b1000000000; #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_gnt_cycle_valid got %b want 0", out_valid); end
    cyc(); #1;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_beat_valid got %b want 1", out_valid); end
    vecs++; if (out_flit !== 16'hC009) begin errs++; $display("FAIL single_beat_flit got %h want C009", out_flit); end
    cyc(); #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL single_release_req got %b want 0", req); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_release_valid got %b want 0", out_valid); end
    cyc(); gnt = '0; #1;
    cyc(); #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL single_idle_req got %b want 0", req); end
  endtask

  task automatic test_stray();
    cyc(); in_valid = 1'b1; in_flit = 16'h0555; #1;
    vecs++; if (drop_err !== 1'b0) begin errs++; $display("FAIL stray_pre_drop got %b want 0", drop_err); end
    cyc(); in_valid = 1'b0; #1;
    vecs++; if (drop_err !== 1'b1) begin errs++; $display("FAIL stray_drop got %b want 1", drop_err); end
    cyc(); #1;
    vecs++; if (drop_err !== 1'b0) begin errs++; $display("FAIL stray_post_drop got %b want 0", drop_err); end
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL stray_req got %b want 0", req); end
  endtask

  task automatic test_drop();
    logic [15:0] flits [3];
    logic        exp_drop [6];
    flits    = '{16'h400C, 16'h0111, 16'h8222};
    exp_drop = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    gnt = 10'h3FF;
    for (int c = 0; c < 6; c++) begin
      cyc();
      in_valid = (c < 3);
      in_flit  = (c < 3) ? flits[c] : 16'h0000;
      #1;
      vecs++; if (drop_err !== exp_drop[c]) begin errs++; $display("FAIL drop_c%0d_err got %b want %b", c, drop_err, exp_drop[c]); end
      vecs++; if (req !== 10'h000) begin errs++; $display("FAIL drop_c%0d_req got %b want 0", c, req); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL drop_c%0d_valid got %b want 0", c, out_valid); end
    end
    gnt = '0;
  endtask

  task automatic test_fill();
    logic [15:0] flits [4];
    logic [15:0] exp_flit [7];
    logic        rdy [7];
    flits    = '{16'h4003, 16'h0AAA, 16'h0BBB, 16'h8CCC};
    exp_flit = '{16'h4003, 16'h0AAA, 16'h0AAA, 16'h0BBB, 16'h0BBB, 16'h8CCC, 16'h8CCC};
    rdy      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      cyc(); in_valid = 1'b1; in_flit = flits[c]; #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fill_c%0d_ready got %b want 1", c, in_ready); end
    end
    cyc(); in_flit = 16'h0DDD; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_full_ready got %b want 0", in_ready); end
    vecs++; if (req !== 10'b0000001000) begin errs++; $display("FAIL fill_req got %b want %b", req, 10'b0000001000); end
    cyc(); in_valid = 1'b0; gnt = 10'b0000001000; #1;
    for (int c = 0; c < 7; c++) begin
      cyc(); out_ready = rdy[c]; #1;
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL fill_b%0d_valid got %b want 1", c, out_valid); end
      vecs++; if (out_flit !== exp_flit[c]) begin errs++; $display("FAIL fill_b%0d_flit got %h want %h", c, out_flit, exp_flit[c]); end
      if (c == 1) begin
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fill_reopen_ready got %b want 1", in_ready); end
      end
    end
    cyc(); out_ready = 1'b1; gnt = '0; #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL fill_release_req got %b want 0", req); end
    cyc(); #1;
  endtask

  task automatic test_back_to_back();
    cyc(); in_valid = 1'b1; in_flit = 16'h4002; #1;
    cyc(); in_flit = 16'h8011; #1;
    cyc(); in_flit = 16'hC102; #1;
    vecs++; if (req !== 10'b0000000100) begin errs++; $display("FAIL b2b_req_a got %b want %b", req, 10'b0000000100); end
    cyc(); in_valid = 1'b0; #1;
    cyc(); gnt = 10'b0000000100; #1;
    cyc(); #1;
    vecs++; if (out_flit !== 16'h4002) begin errs++; $display("FAIL b2b_a0_flit got %h want 4002", out_flit); end
    cyc(); #1;
    vecs++; if (out_flit !== 16'h8011) begin errs++; $display("FAIL b2b_a1_flit got %h want 8011", out_flit); end
    // grant stays high for two cycles after the tail: it must not be reused
    for (int c = 0; c < 2; c++) begin
      cyc(); #1;
      vecs++; if (req !== 10'h000) begin errs++; $display("FAIL b2b_stale%0d_req got %b want 0", c, req); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_stale%0d_valid got %b want 0", c, out_valid); end
    end
    cyc(); gnt = '0; #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL b2b_gap_rel_req got %b want 0", req); end
    cyc(); #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL b2b_gap_idle_req got %b want 0", req); end
    for (int c = 0; c < 2; c++) begin
      cyc(); #1;
      vecs++; if (req !== 10'b0000000100) begin errs++; $display("FAIL b2b_req_b%0d got %b want %b", c, req, 10'b0000000100); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_wait%0d_valid got %b want 0", c, out_valid); end
    end
    cyc(); gnt = 10'b0000000100; #1;
    cyc(); #1;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_b_valid got %b want 1", out_valid); end
    vecs++; if (out_flit !== 16'hC102) begin errs++; $display("FAIL b2b_b_flit got %h want C102", out_flit); end
    cyc(); gnt = '0; #1;
    cyc(); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] flits [4];
    flits = '{16'h4007, 16'h0001, 16'h0002, 16'h8003};
    for (int c = 0; c < 4; c++) begin
      cyc(); in_valid = 1'b1; in_flit = flits[c]; #1;
    end
    cyc(); in_valid = 1'b0; gnt = 10'b0010000000; #1;
    cyc(); #1;
    vecs++; if (out_flit !== 16'h4007) begin errs++; $display("FAIL rmid_first_flit got %h want 4007", out_flit); end
    cyc(); #1;
    vecs++; if (out_flit !== 16'h0001) begin errs++; $display("FAIL rmid_second_flit got %h want 0001", out_flit); end
    rst = 1'b1; #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL rmid_req got %b want 0", req); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rmid_in_ready got %b want 0", in_ready); end
    cyc(); rst = 1'b0; gnt = 10'b0000000001; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rmid_rel_ready got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_rel_valid got %b want 0", out_valid); end
    gnt = '0;
    cyc(); in_valid = 1'b1; in_flit = 16'hC000; #1;
    cyc(); in_valid = 1'b0; #1;
    cyc(); #1;
    vecs++; if (req !== 10'b0000000001) begin errs++; $display("FAIL rmid_new_req got %b want %b", req, 10'b0000000001); end
    cyc(); #1;
    cyc(); gnt = 10'b0000000001; #1;
    cyc(); #1;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rmid_new_valid got %b want 1", out_valid); end
    vecs++; if (out_flit !== 16'hC000) begin errs++; $display("FAIL rmid_new_flit got %h want C000", out_flit); end
    cyc(); #1;
    vecs++; if (req !== 10'h000) begin errs++; $display("FAIL rmid_new_release got %b want 0", req); end
    cyc(); gnt = '0; #1;
    cyc(); #1;
  endtask

  initial begin
    test_reset();
    test_three_flit();
    test_single();
    test_stray();
    test_drop();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
